// File: rtl/blake_pkg.sv
// Shared definitions for the BLAKE-512 compression datapath: round geometry,
// sequencer state encoding and the sigma permutation row selector.
package blake_pkg;

  localparam int unsigned N_ROUNDS    = 16;
  localparam int unsigned G_PER_ROUND = 8;
  localparam int unsigned STEP_W      = 7;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRun,
    StFin,
    StDone
  } state_e;

  // The ten sigma permutations repeat, so rounds 10..15 reuse rows 0..5.
  function automatic logic [3:0] sigma_row_of(input logic [3:0] round);
    return (round >= 4'd10) ? round - 4'd10 : round;
  endfunction

endpackage

// File: rtl/blake_round_ctrl.sv
// Sequencer for the BLAKE-512 compression datapath: IV load, 16x8 G steps with
// datapath back-pressure, digest capture and a valid/ready handshake to the consumer.
module blake_round_ctrl #(
  parameter int unsigned N_ROUNDS    = blake_pkg::N_ROUNDS,
  parameter int unsigned G_PER_ROUND = blake_pkg::G_PER_ROUND
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       start,
  output logic       start_ready,
  input  logic       abort,
  input  logic       rdy,
  output logic       init_round,
  output logic       step_en,
  output logic [3:0] round_idx,
  output logic [2:0] g_sel,
  output logic [3:0] sigma_row,
  output logic       count_done,
  output logic       busy,
  output logic       dout_valid,
  input  logic       dout_ready
);
  import blake_pkg::*;

  localparam logic [STEP_W-1:0] LastStep = STEP_W'(N_ROUNDS * G_PER_ROUND - 1);

  state_e            state_q;
  logic [STEP_W-1:0] step_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= StIdle;
      step_q     <= '0;
      init_round <= 1'b0;
      count_done <= 1'b0;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
    end else if (abort) begin
      state_q    <= StIdle;
      step_q     <= '0;
      init_round <= 1'b0;
      count_done <= 1'b0;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      init_round <= 1'b0;
      count_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StInit;
            init_round <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StInit: begin
          state_q <= StRun;
          step_q  <= '0;
        end
        StRun: begin
          if (rdy) begin
            if (step_q == LastStep) begin
              // Clearing here keeps the indices at zero outside the run.
              state_q    <= StFin;
              step_q     <= '0;
              count_done <= 1'b1;
            end else begin
              step_q <= step_q + STEP_W'(1);
            end
          end
        end
        StFin: begin
          state_q    <= StDone;
          busy       <= 1'b0;
          dout_valid <= 1'b1;
        end
        StDone: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            if (start) begin
              state_q    <= StInit;
              init_round <= 1'b1;
              busy       <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    start_ready = (state_q == StIdle) || ((state_q == StDone) && dout_ready);
    step_en     = (state_q == StRun) && rdy;
    round_idx   = step_q[STEP_W-1:3];
    g_sel       = step_q[2:0];
    sigma_row   = sigma_row_of(step_q[STEP_W-1:3]);
  end

endmodule

// File: doc/blake_round_ctrl.md
# blake_round_ctrl

Sequencer for the BLAKE-512 single-block compression datapath. It accepts a start request, pulses `init_round` to load IV into the chaining/finalize registers, and steps the G-function datapath through 16 rounds × 8 G steps. It drives the per-step round, G and sigma indices, stalls on the datapath's `rdy`, pulses `count_done` so the finalize stage captures the digest, and holds `dout_valid` until the consumer accepts it.

## Interface
- `N_ROUNDS`, 16, number of rounds per block (≥1, ≤16)
- `G_PER_ROUND`, 8, G steps per round (power of two, fixed 8 for BLAKE-512)
- `clk` input 1 rising-edge clock
- `rstb` input 1 reset; one clock; reset is asynchronous and active-low
- `start` input 1 request to hash one block (message already presented to datapath)
- `start_ready` output 1 block can accept `start` this cycle
- `abort` input 1 synchronous cancel, any state
- `rdy` input 1 datapath can execute a G step this cycle
- `init_round` output 1 one-cycle pulse: load IV / clear finalize output
- `step_en` output 1 G step executes this cycle (`RUN` and `rdy`)
- `round_idx` output 4 current round 0..N_ROUNDS-1
- `g_sel` output 3 current G index 0..7 (columns 0-3, diagonals 4-7)
- `sigma_row` output 4 `round_idx` mod 10
- `count_done` output 1 one-cycle pulse: finalize captures digest
- `busy` output 1 high in `INIT`, `RUN`, `FIN`
- `dout_valid` output 1 digest on finalize `dout` is valid
- `dout_ready` input 1 consumer accepts digest

## Operation
- States: `IDLE`, `INIT`, `RUN`, `FIN`, `DONE`.
- `IDLE`: `start_ready`=1; `start` → `INIT`.
- `INIT`: `init_round`=1 for exactly one cycle; step counter cleared; → `RUN`.
- `RUN`: 7-bit step counter `{round_idx, g_sel}` increments only when `rdy`=1. When `rdy`=0, the counter and indices hold and `step_en`=0. On the step with `round_idx`=N_ROUNDS-1, `g_sel`=7 and `rdy`=1 → `FIN`.
- `FIN`: `count_done`=1 for one cycle; → `DONE`.
- `DONE`: `dout_valid`=1 until `dout_ready`=1.
  - If `start` is also high on that cycle (`start_ready`=1 in `DONE` when `dout_ready`=1) → `INIT` directly (back-to-back).
  - Otherwise → `IDLE`.
- `sigma_row` = `round_idx` ≥ 10 ? `round_idx` − 10 : `round_idx`. Combinational from the counter.
- `round_idx`/`g_sel` read 0 outside `RUN`. The counter never wraps; `FIN` is entered instead.
- `abort`: takes priority over every transition → `IDLE` next cycle.
  - No `count_done` is issued; `dout_valid` drops.
  - `abort` with `start` in the same cycle: `abort` wins, `start` is not accepted.
- `start` outside `start_ready` is ignored, not queued.
- Reset (any time, including mid-`RUN`): state `IDLE`, counter 0, all outputs 0 except `start_ready`=1.

## Timing
- Edge 0 samples `start`=1 in `IDLE`. Cycle 1: `INIT`. Cycles 2..129: `RUN` steps 0..127 (`rdy` held 1). Cycle 130: `FIN`/`count_done`. Cycle 131: `dout_valid`=1.
- Latency `start` → `dout_valid` = 3 + N_ROUNDS·8 + (number of `RUN` cycles with `rdy`=0). With defaults and no stalls: 131.
- All outputs are registered-state decodes; no combinational path from `start`/`dout_ready` to any output except `start_ready` (from `dout_ready` in `DONE`) and `step_en` (from `rdy`).
- Back-to-back throughput: one block per 131 cycles with consumer always ready.

## Structure
- `blake_pkg` holds `N_ROUNDS`, `G_PER_ROUND`, the state enum (`IDLE`/`INIT`/`RUN`/`FIN`/`DONE`) and the sigma-row modulo function. The finalize and round datapath modules share these.
- No sub-module; FSM, step counter and sigma decode are inline (~150–250 lines).

## Test plan
- Reset then `start` pulse, `rdy`=1, `dout_ready`=1 → `init_round` in cycle 1, `step_en` for 128 cycles, `count_done` in cycle 130, `dout_valid` in cycle 131 for one cycle, back in `IDLE`.
- Index sweep → `g_sel` cycles 0..7 per round, `round_idx` 0..15, `sigma_row` sequence 0..9,0..5; with finalize attached, an all-zero block gives the BLAKE-512 known-answer digest.
- `rdy` low for 5 cycles at step 40 and 3 cycles at step 127 → indices hold, `step_en`=0, `count_done` at cycle 138.
- `dout_ready`=0 for 10 cycles in `DONE` → `dout_valid` held 10+1 cycles; `start` ignored until `dout_ready`=1; `start` with `dout_ready` → `init_round` next cycle.
- `abort` at step 60 (also with `start`) → `IDLE` next cycle, no `count_done`, no `dout_valid`; subsequent `start` completes normally.
- `rstb` low mid-`RUN` at step 90 → outputs zero immediately (async), `start_ready`=1 after release, clean full run afterwards.
